// File: rtl/mul_sequencer.sv
// Iterative shift-add sequencer for MUL/MULH/MULHSU/MULHU with a valid/ready request and response.
// Optional macro MUL_EARLY_OUT_EN ends the CALC loop once the remaining multiplier bits are zero.
module mul_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [4:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            err_o,
    output logic            busy_o
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [4:0] OpMul    = 5'b0_1000;
    localparam logic [4:0] OpMulh   = 5'b0_1001;
    localparam logic [4:0] OpMulhsu = 5'b0_1010;
    localparam logic [4:0] OpMulhu  = 5'b0_1011;

    logic [1:0]        state_q, state_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              is_mul_q, is_mul_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              err_q, err_d;

    logic              op_supported;
    logic              rs1_neg;
    logic              rs2_neg;
    logic [XLEN-1:0]   rs1_mag;
    logic [XLEN-1:0]   rs2_mag;
    logic [2*XLEN-1:0] acc_fix;

    // Only operands treated as signed by the op contribute a sign; magnitude of MIN stays MIN.
    always_comb begin
        op_supported = (funct3_i == OpMul) || (funct3_i == OpMulh) ||
                       (funct3_i == OpMulhsu) || (funct3_i == OpMulhu);
        rs1_neg = rs1_i[XLEN-1] && ((funct3_i == OpMulh) || (funct3_i == OpMulhsu));
        rs2_neg = rs2_i[XLEN-1] && (funct3_i == OpMulh);
        rs1_mag = rs1_neg ? -rs1_i : rs1_i;
        rs2_mag = rs2_neg ? -rs2_i : rs2_i;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        is_mul_d = is_mul_q;
        result_d = result_q;
        err_d    = err_q;
        acc_fix  = neg_q ? -acc_q : acc_q;

        case (state_q)
            StIdle: begin
                if (req_valid_i && !flush_i) begin
                    if (op_supported) begin
                        mcand_d  = {{XLEN{1'b0}}, rs1_mag};
                        mplier_d = rs2_mag;
                        acc_d    = '0;
                        cnt_d    = '0;
                        neg_d    = rs1_neg ^ rs2_neg;
                        is_mul_d = (funct3_i == OpMul);
                        state_d  = StCalc;
                    end else begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = StDone;
                    end
                end
            end
            StCalc: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntOne;
`ifdef MUL_EARLY_OUT_EN
                if ((cnt_q == CntLast) || (mplier_d == '0)) begin
                    state_d = StFix;
                end
`else
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                end
`endif
            end
            StFix: begin
                result_d = is_mul_q ? acc_fix[XLEN-1:0] : acc_fix[2*XLEN-1:XLEN];
                err_d    = 1'b0;
                state_d  = StDone;
            end
            StDone: begin
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            is_mul_q <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            is_mul_q <= is_mul_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign resp_valid_o = (state_q == StDone);
    assign result_o     = result_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: directed cases plus random ops checked against a 64-bit product model.
// Latency expectations follow MUL_EARLY_OUT_EN when the bench is built with it.
module tb_mul_sequencer;

    localparam int XLEN = 32;
`ifdef MUL_EARLY_OUT_EN
    localparam bit EarlyOut = 1'b1;
`else
    localparam bit EarlyOut = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [4:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic [XLEN-1:0] result_o;
    logic            err_o;
    logic            busy_o;

    int checks = 0;
    int errors = 0;

    mul_sequencer #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .funct3_i    (funct3_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .flush_i     (flush_i),
        .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i),
        .result_o    (result_o),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit supported(input logic [4:0] f);
        return (f == 5'b0_1000) || (f == 5'b0_1001) || (f == 5'b0_1010) || (f == 5'b0_1011);
    endfunction

    // Full 64-bit product of the operands extended per op; the product mod 2^64 is exact.
    function automatic logic [31:0] ref_result(input logic [4:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] ea, eb, p;
        if (!supported(f)) return 32'h0;
        ea = (f == 5'b0_1001 || f == 5'b0_1010) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (f == 5'b0_1001) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (f == 5'b0_1000) ? p[31:0] : p[63:32];
    endfunction

    function automatic int ref_latency(input logic [4:0] f, input logic [31:0] b);
        logic [31:0] mag;
        int k, c;
        if (!supported(f)) return 1;
        mag = (f == 5'b0_1001 && b[31]) ? (32'h0 - b) : b;
        k = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
        c = EarlyOut ? ((k == 0) ? 1 : k) : 32;
        return c + 2;
    endfunction

    // Entered and left at 1 time unit after a rising edge; returns with the response visible.
    task automatic start_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
        funct3_i    = f;
        rs1_i       = a;
        rs2_i       = b;
        req_valid_i = 1'b1;
        check("req_ready_before_accept", req_ready_o, 1'b1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        check("busy_after_accept", busy_o, 1'b1);
        check("req_ready_after_accept", req_ready_o, 1'b0);
        lat = 1;
        while (resp_valid_o !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic end_op(input int hold, input logic [31:0] exp_res, input logic exp_err);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", resp_valid_o, 1'b1);
            check("hold_result", result_o, exp_res);
            check("hold_err", err_o, exp_err);
            @(posedge clk);
            #1;
        end
        resp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        resp_ready_i = 1'b0;
        check("resp_valid_after_hs", resp_valid_o, 1'b0);
        check("req_ready_after_hs", req_ready_o, 1'b1);
        check("busy_after_hs", busy_o, 1'b0);
    endtask

    task automatic run_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        int lat;
        logic [31:0] exp_res;
        exp_res = ref_result(f, a, b);
        start_op(f, a, b, lat);
        check("latency", lat, ref_latency(f, b));
        check("result", result_o, exp_res);
        check("err", err_o, !supported(f));
        end_op(hold, exp_res, !supported(f));
    endtask

    initial begin
        int lat;
        int sel, mode;
        logic [4:0] f;
        logic [31:0] a, b;
        logic [31:0] corners [5];
        corners[0] = 32'h0;
        corners[1] = 32'h1;
        corners[2] = 32'h8000_0000;
        corners[3] = 32'hFFFF_FFFF;
        corners[4] = 32'h7FFF_FFFF;

        rst          = 1'b1;
        req_valid_i  = 1'b0;
        funct3_i     = '0;
        rs1_i        = '0;
        rs2_i        = '0;
        flush_i      = 1'b0;
        resp_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_resp_valid", resp_valid_o, 1'b0);
        check("rst_result", result_o, 32'h0);
        check("rst_err", err_o, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(5'b0_1000, 32'h7, 32'hFFFF_FFFD, 0);
        run_op(5'b0_1001, 32'h8000_0000, 32'h8000_0000, 1);
        run_op(5'b0_1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(5'b0_1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(5'b0_1000, 32'h5, 32'h3, 0);
        run_op(5'b0_1000, 32'h1234_5678, 32'h0, 0);
        run_op(5'b0_1001, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 0);

        // Response held for 10 cycles with resp_ready low.
        run_op(5'b0_1001, 32'hDEAD_BEEF, 32'h1357_9BDF, 10);

        // Unsupported funct3 (ADD).
        run_op(5'b0_0000, 32'h1111_1111, 32'h2222_2222, 2);

        // Flush in the 5th CALC cycle while a new request is offered.
        funct3_i    = 5'b0_1011;
        rs1_i       = 32'hAAAA_5555;
        rs2_i       = 32'hFFFF_0001;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("flush_pre_busy", busy_o, 1'b1);
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        funct3_i    = 5'b0_0000;
        @(posedge clk);
        #1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        check("flush_busy", busy_o, 1'b0);
        check("flush_resp_valid", resp_valid_o, 1'b0);
        check("flush_req_ready", req_ready_o, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        check("flush_no_resp", resp_valid_o, 1'b0);
        check("flush_still_idle", busy_o, 1'b0);
        run_op(5'b0_1011, 32'hAAAA_5555, 32'hFFFF_0001, 0);

        // Flush in DONE beats a same-cycle response handshake.
        start_op(5'b0_1000, 32'h9, 32'h9, lat);
        check("done_flush_lat", lat, ref_latency(5'b0_1000, 32'h9));
        check("done_flush_result", result_o, 32'd81);
        flush_i      = 1'b1;
        resp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i      = 1'b0;
        resp_ready_i = 1'b0;
        check("done_flush_valid", resp_valid_o, 1'b0);
        check("done_flush_ready", req_ready_o, 1'b1);

        for (int n = 0; n < 25; n++) begin
            sel = $urandom_range(0, 4);
            if (sel < 4) begin
                f = 5'b0_1000 | 5'(sel);
            end else begin
                f = 5'($urandom_range(0, 31));
                if (supported(f)) f = 5'b1_0000;
            end
            mode = $urandom_range(0, 2);
            a = (mode == 2) ? corners[$urandom_range(0, 4)] : $urandom;
            mode = $urandom_range(0, 2);
            b = (mode == 0) ? $urandom : (mode == 1) ? 32'($urandom_range(0, 15))
                                                     : corners[$urandom_range(0, 4)];
            run_op(f, a, b, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative multi-cycle sequencer for the RV32M multiply group (MUL, MULH, MULHSU, MULHU) of the core's opfunct3 encoding. Sits beside the execute-stage ALU. Accepts one request via valid/ready, runs a shift-add datapath under a small FSM, and returns a single XLEN-bit result via valid/ready. The pipeline stalls on `busy_o`.

## Interface
- `XLEN`, 32: operand/result width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request ready; high only in IDLE.
- `funct3_i`  in  5  opfunct3 `{instr[30], instr[25], instr[14:12]}`.
- `rs1_i`  in  XLEN  multiplicand operand.
- `rs2_i`  in  XLEN  multiplier operand.
- `flush_i`  in  1  abort the operation in flight.
- `resp_valid_o`  out  1  result valid.
- `resp_ready_i`  in  1  result consumed.
- `result_o`  out  XLEN  result, held stable while `resp_valid_o` is high.
- `err_o`  out  1  request used an unsupported funct3; qualified by `resp_valid_o`.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- Supported codes:
  - MUL = 5'b0_1000: low half of the product; signedness is irrelevant.
  - MULH = 5'b0_1001: signed × signed, high half.
  - MULHSU = 5'b0_1010: rs1 signed × rs2 unsigned, high half.
  - MULHU = 5'b0_1011: unsigned × unsigned, high half.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - On `req_valid_i & req_ready_o`, latch the operation.
  - Supported op: load the magnitudes of the operands that are signed for this op (two's-complement negate when the MSB is set). Load 2·XLEN multiplicand register = zero-extended |rs1|, multiplier register = |rs2|, accumulator = 0, counter = 0. Latch the result sign as the XOR of the effective operand signs. Go to CALC.
  - Unsupported op: result = 0, `err_o` = 1, go directly to DONE.
- CALC, once per cycle:
  - If multiplier LSB = 1, accumulator += multiplicand.
  - Multiplicand <<= 1, multiplier >>= 1, counter += 1.
  - Go to FIX when counter reaches XLEN−1 (i.e. this is the XLEN-th CALC cycle); otherwise stay.
- FIX:
  - If the sign bit is set, two's-complement negate the full 2·XLEN accumulator.
  - `result_o` = accumulator[XLEN−1:0] for MUL, else accumulator[2·XLEN−1:XLEN].
  - `err_o` = 0. Go to DONE.
- DONE:
  - `resp_valid_o` = 1.
  - On `resp_ready_i`, go to IDLE. Otherwise hold `result_o` and `err_o` unchanged indefinitely.
- Arithmetic:
  - Accumulator is 2·XLEN bits wide; it never overflows because |a|·|b| < 2^(2·XLEN).
  - The magnitude of 0x8000_0000 is 0x8000_0000, interpreted as unsigned.
- `flush_i`:
  - In any state, the next state is IDLE and `resp_valid_o` drops at that edge.
  - Flush has priority over a same-cycle request; that request is not accepted.
  - A flush in DONE discards the result even if `resp_ready_i` is high in the same cycle.
- `rst`: same effect as flush, and additionally clears all registers.

## Timing
- Reset values: state IDLE, `req_ready_o` = 1, `busy_o` = 0, `resp_valid_o` = 0, `result_o` = 0, `err_o` = 0.
- Let c = number of CALC cycles (XLEN with the early-out feature disabled).
- Latency:
  - `resp_valid_o` first goes high c+2 cycles after the accept cycle (34 for XLEN = 32).
  - Unsupported funct3: 1 cycle after the accept cycle.
- Throughput:
  - `req_ready_o` is low from the edge after acceptance until the DONE→IDLE edge.
  - A new request is accepted at the earliest one cycle after the response handshake. There is no DONE→CALC bypass.
- `busy_o` is registered state decode; it has no combinational path from inputs.

## Configuration
- `MUL_EARLY_OUT_EN` defined:
  - In CALC, go to FIX at the end of any cycle in which the post-shift multiplier register is zero, or the counter reaches XLEN−1.
  - c = max(k, 1), where k = bit position of the highest set bit of the multiplier magnitude, plus 1 (k = 0 when the magnitude is zero).
- Undefined: c = XLEN always; no zero-detect logic is compiled.
- Results are identical in both builds; only latency differs.

## Test plan
- MUL rs1=7, rs2=0xFFFF_FFFD → `result_o`=0xFFFF_FFEB, `err_o`=0, `resp_valid_o` high 34 cycles after accept (macro off).
- MULH 0x8000_0000 × 0x8000_0000 → 0x4000_0000. MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE. MULHSU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFF.
- Hold `resp_ready_i`=0 for 10 cycles in DONE → `resp_valid_o` and `result_o` stable. Assert `resp_ready_i` → IDLE next edge, `req_ready_o`=1.
- `flush_i` at CALC cycle 5 with `req_valid_i` high → IDLE next edge, no response, request not accepted. Next request then completes normally.
- funct3=5'b0_0000 (ADD) → `resp_valid_o` 1 cycle after accept, `err_o`=1, `result_o`=0.
- `MUL_EARLY_OUT_EN` defined: MUL 5×3 → 15 with c=2 (latency 4); rs2=0 → 0 with c=1. Macro off: same results, latency 34.
